// File: rtl/fsm_state_monitor.sv
// Passive observer of the 3-state control FSM: transition pulses, dwell time, visit counts, sticky flags.
// Every output registered, 1-cycle latency from st_in; no flow control, nothing is driven back into the FSM.
module fsm_state_monitor #(
   parameter int CW = 16,
   parameter int VW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [1:0]    st_in,
   input  logic [1:0]    c0,
   input  logic [1:0]    c1,
   input  logic [1:0]    c2,
   input  logic [CW-1:0] timeout,
   input  logic          clr,
   output logic          trans,
   output logic [1:0]    from_st,
   output logic [1:0]    to_st,
   output logic [CW-1:0] dwell,
   output logic [VW-1:0] visits0,
   output logic [VW-1:0] visits1,
   output logic [VW-1:0] visits2,
   output logic          illegal,
   output logic          tmo_pulse,
   output logic          tmo
);

   logic [1:0]    prev_q, prev_d;
   logic          vld_q, vld_d;
   logic          trans_q, trans_d;
   logic [1:0]    from_st_q, from_st_d;
   logic [1:0]    to_st_q, to_st_d;
   logic [CW-1:0] dwell_q, dwell_d;
   logic [VW-1:0] visits0_q, visits0_d;
   logic [VW-1:0] visits1_q, visits1_d;
   logic [VW-1:0] visits2_q, visits2_d;
   logic          illegal_q, illegal_d;
   logic          tmo_pulse_q, tmo_pulse_d;
   logic          tmo_q, tmo_d;

   logic          hit0, hit1, hit2, legal;
   logic          change, entry, tmo_hit;
   logic [VW-1:0] base0, base1, base2;

   function automatic logic [VW-1:0] sat_inc(input logic [VW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Fixed priority: when encodings collide the lowest index claims the code.
   always_comb begin
      hit0  = (st_in == c0);
      hit1  = !hit0 && (st_in == c1);
      hit2  = !hit0 && !hit1 && (st_in == c2);
      legal = hit0 || hit1 || hit2;
   end

   always_comb begin
      change = vld_q && (st_in != prev_q);
      entry  = !vld_q || change;

      prev_d      = st_in;
      vld_d       = 1'b1;
      trans_d     = change;
      from_st_d   = change ? prev_q : from_st_q;
      to_st_d     = change ? st_in  : to_st_q;
      dwell_d     = entry ? '0 : ((&dwell_q) ? dwell_q : dwell_q + 1'b1);

      // A saturated dwell does not move, so it must not re-trigger the timeout.
      tmo_hit     = (timeout != '0) && !entry && !(&dwell_q) && (dwell_d == timeout);
      tmo_pulse_d = tmo_hit;

      base0 = clr ? '0 : visits0_q;
      base1 = clr ? '0 : visits1_q;
      base2 = clr ? '0 : visits2_q;
      visits0_d = (entry && hit0) ? sat_inc(base0) : base0;
      visits1_d = (entry && hit1) ? sat_inc(base1) : base1;
      visits2_d = (entry && hit2) ? sat_inc(base2) : base2;

      illegal_d = (clr ? 1'b0 : illegal_q) || !legal;
      tmo_d     = (clr ? 1'b0 : tmo_q) || tmo_hit;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q      <= '0;
         vld_q       <= 1'b0;
         trans_q     <= 1'b0;
         from_st_q   <= '0;
         to_st_q     <= '0;
         dwell_q     <= '0;
         visits0_q   <= '0;
         visits1_q   <= '0;
         visits2_q   <= '0;
         illegal_q   <= 1'b0;
         tmo_pulse_q <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         vld_q       <= vld_d;
         trans_q     <= trans_d;
         from_st_q   <= from_st_d;
         to_st_q     <= to_st_d;
         dwell_q     <= dwell_d;
         visits0_q   <= visits0_d;
         visits1_q   <= visits1_d;
         visits2_q   <= visits2_d;
         illegal_q   <= illegal_d;
         tmo_pulse_q <= tmo_pulse_d;
         tmo_q       <= tmo_d;
      end
   end

   assign trans     = trans_q;
   assign from_st   = from_st_q;
   assign to_st     = to_st_q;
   assign dwell     = dwell_q;
   assign visits0   = visits0_q;
   assign visits1   = visits1_q;
   assign visits2   = visits2_q;
   assign illegal   = illegal_q;
   assign tmo_pulse = tmo_pulse_q;
   assign tmo       = tmo_q;

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Directed bench for fsm_state_monitor; VW=2 so visit saturation is reachable quickly.
module tb_fsm_state_monitor;

   localparam int CW = 16;
   localparam int VW = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    st_in = 2'b01;
   logic [1:0]    c0 = 2'b01, c1 = 2'b10, c2 = 2'b11;
   logic [CW-1:0] timeout = '0;
   logic          clr = 1'b0;
   logic          trans, illegal, tmo_pulse, tmo;
   logic [1:0]    from_st, to_st;
   logic [CW-1:0] dwell;
   logic [VW-1:0] visits0, visits1, visits2;

   int total = 0;
   int bad   = 0;

   fsm_state_monitor #(.CW(CW), .VW(VW)) dut (
      .clock(clock), .reset(reset), .st_in(st_in), .c0(c0), .c1(c1), .c2(c2),
      .timeout(timeout), .clr(clr), .trans(trans), .from_st(from_st), .to_st(to_st),
      .dwell(dwell), .visits0(visits0), .visits1(visits1), .visits2(visits2),
      .illegal(illegal), .tmo_pulse(tmo_pulse), .tmo(tmo)
   );

   always #5 clock = ~clock;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_visits(input string tag, input int v0, input int v1, input int v2);
      chk_eq({tag, ".v0"}, 32'(visits0), 32'(v0));
      chk_eq({tag, ".v1"}, 32'(visits1), 32'(v1));
      chk_eq({tag, ".v2"}, 32'(visits2), 32'(v2));
   endtask

   task automatic chk_trans(input string tag, input logic [1:0] f, input logic [1:0] t);
      chk_eq({tag, ".trans"}, 32'(trans), 32'd1);
      chk_eq({tag, ".from"},  32'(from_st), 32'(f));
      chk_eq({tag, ".to"},    32'(to_st), 32'(t));
      chk_eq({tag, ".dwell"}, 32'(dwell), 32'd0);
   endtask

   // Reset with st_in already set, then release: the returned state is just after first capture.
   task automatic restart(input logic [1:0] s);
      reset = 1'b1;
      st_in = s;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      // Reset state
      tick(); tick();
      chk_eq("rst.trans", 32'(trans), 32'd0);
      chk_eq("rst.from",  32'(from_st), 32'd0);
      chk_eq("rst.to",    32'(to_st), 32'd0);
      chk_eq("rst.dwell", 32'(dwell), 32'd0);
      chk_eq("rst.ill",   32'(illegal), 32'd0);
      chk_eq("rst.tmo",   32'(tmo), 32'd0);
      chk_eq("rst.tmop",  32'(tmo_pulse), 32'd0);
      chk_visits("rst", 0, 0, 0);

      // Basic walk
      reset = 1'b0;
      tick();
      chk_eq("walk.cap.trans", 32'(trans), 32'd0);
      chk_eq("walk.cap.dwell", 32'(dwell), 32'd0);
      chk_visits("walk.cap", 1, 0, 0);
      tick(); tick();
      chk_eq("walk.dwell2", 32'(dwell), 32'd2);
      st_in = 2'b10; tick();
      chk_trans("walk.t1", 2'b01, 2'b10);
      st_in = 2'b11; tick();
      chk_trans("walk.t2", 2'b10, 2'b11);
      st_in = 2'b01; tick();
      chk_trans("walk.t3", 2'b11, 2'b01);
      chk_visits("walk.end", 2, 1, 1);
      tick();
      chk_eq("walk.hold.trans", 32'(trans), 32'd0);
      chk_eq("walk.hold.from",  32'(from_st), 32'd3);
      chk_eq("walk.hold.to",    32'(to_st), 32'd1);
      chk_eq("walk.hold.dwell", 32'(dwell), 32'd1);
      chk_eq("walk.tmo0",       32'(tmo), 32'd0);

      // Timeout fires once at dwell=5
      timeout = 16'd5;
      restart(2'b10);
      chk_visits("tmo.cap", 0, 1, 0);
      for (int n = 1; n <= 4; n++) begin
         tick();
         chk_eq("tmo.pre.dwell", 32'(dwell), 32'(n));
         chk_eq("tmo.pre.pulse", 32'(tmo_pulse), 32'd0);
      end
      tick();
      chk_eq("tmo.hit.dwell", 32'(dwell), 32'd5);
      chk_eq("tmo.hit.pulse", 32'(tmo_pulse), 32'd1);
      chk_eq("tmo.hit.tmo",   32'(tmo), 32'd1);
      tick();
      chk_eq("tmo.post.pulse", 32'(tmo_pulse), 32'd0);
      chk_eq("tmo.post.tmo",   32'(tmo), 32'd1);
      chk_eq("tmo.post.dwell", 32'(dwell), 32'd6);

      // Leaving at dwell=4: transition wins over timeout
      restart(2'b10);
      repeat (4) tick();
      chk_eq("tmo2.dwell4", 32'(dwell), 32'd4);
      st_in = 2'b01; tick();
      chk_trans("tmo2.leave", 2'b10, 2'b01);
      chk_eq("tmo2.pulse", 32'(tmo_pulse), 32'd0);
      tick();
      chk_eq("tmo2.tmo", 32'(tmo), 32'd0);

      // Illegal code between 01 and 10
      timeout = '0;
      restart(2'b01);
      chk_eq("ill.cap", 32'(illegal), 32'd0);
      st_in = 2'b00; tick();
      chk_trans("ill.in", 2'b01, 2'b00);
      chk_eq("ill.flag", 32'(illegal), 32'd1);
      chk_visits("ill.in", 1, 0, 0);
      st_in = 2'b10; tick();
      chk_trans("ill.out", 2'b00, 2'b10);
      chk_visits("ill.out", 1, 1, 0);
      tick();
      chk_eq("ill.sticky", 32'(illegal), 32'd1);

      // Saturation of 2-bit visit counters
      restart(2'b01);
      for (int i = 1; i <= 5; i++) begin
         st_in = 2'b10; tick();
         chk_eq("sat.v1", 32'(visits1), 32'((i < 3) ? i : 3));
         st_in = 2'b01; tick();
      end
      chk_visits("sat.end", 3, 3, 0);

      // clr coinciding with a transition into c2
      restart(2'b01);
      st_in = 2'b10; tick();
      st_in = 2'b11; clr = 1'b1; tick();
      clr = 1'b0;
      chk_trans("clr.tr", 2'b10, 2'b11);
      chk_visits("clr.tr", 0, 0, 1);

      // clr coinciding with an illegal sample
      st_in = 2'b00; tick();
      clr = 1'b1; tick();
      clr = 1'b0;
      chk_eq("clr.ill", 32'(illegal), 32'd1);

      // Plain clr clears flags and counters, but not dwell
      timeout = 16'd2;
      st_in = 2'b01; tick();
      tick(); tick();
      chk_eq("clr.tmo.set", 32'(tmo), 32'd1);
      clr = 1'b1; tick();
      clr = 1'b0;
      chk_eq("clr.plain.ill", 32'(illegal), 32'd0);
      chk_eq("clr.plain.tmo", 32'(tmo), 32'd0);
      chk_eq("clr.plain.dwell", 32'(dwell), 32'd3);
      chk_visits("clr.plain", 0, 0, 0);

      // Reset mid-residency at dwell=7 in c1
      timeout = '0;
      st_in = 2'b00; tick();
      st_in = 2'b10; tick();
      repeat (7) tick();
      chk_eq("mid.dwell7", 32'(dwell), 32'd7);
      restart(2'b10);
      chk_eq("mid.trans", 32'(trans), 32'd0);
      chk_eq("mid.dwell", 32'(dwell), 32'd0);
      chk_eq("mid.ill",   32'(illegal), 32'd0);
      chk_eq("mid.tmo",   32'(tmo), 32'd0);
      chk_visits("mid", 0, 1, 0);
      tick();
      chk_eq("mid.dwell1", 32'(dwell), 32'd1);

      // Colliding encodings: lowest index claims the code
      c1 = 2'b01;
      restart(2'b01);
      chk_visits("coll", 1, 0, 0);
      c1 = 2'b10;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
